dmem_host_port: RTL and testbench
=================================

Name: dmem_host_port

Overview:
- Host-side initiator for the core's data memory.
- Holds the core in reset while it streams bytes into data memory, then releases the core and waits for its done flag.
- After done, re-asserts core reset and streams a window of data memory back out as result bytes.
- Sits between the bench/host byte streams and the core's top level: drives core reset and the data-memory port, reads core done.

Parameters:
- LOAD_BASE, 0, first data-memory address written during load.
- LOAD_LEN, 64, number of bytes loaded; legal range 1..256.
- DUMP_BASE, 64, first data-memory address read during dump.
- DUMP_LEN, 32, number of bytes dumped; legal range 1..256.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a load/run/dump sequence; sampled only in IDLE
- in_data  input  8  load byte
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data
- mem_addr  output  8  data-memory address
- mem_wr_en  output  1  data-memory write enable
- mem_wdata  output  8  data-memory write data
- mem_rdata  input  8  data-memory read data; combinational from mem_addr
- core_reset  output  1  reset to core; high except in RUN
- core_done  input  1  core done flag
- out_data  output  8  dump byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high in every state except IDLE

Behaviour:
- Asynchronous reset values:
  - State IDLE, byte count 0, first-cycle flag 0.
  - core_reset=1; busy, in_ready, out_valid, mem_wr_en = 0; mem_addr=0, mem_wdata=0, out_data=0.
- Outputs decode combinationally from registered state and count.
- States: IDLE, LOAD, RUN, DUMP, plus CSUM when CHECKSUM_EN is defined.
- IDLE:
  - mem_addr=0, all strobes 0.
  - start=1 -> LOAD, count=0.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1; mem_addr=(LOAD_BASE+count) mod 256; mem_wdata=in_data; mem_wr_en=in_valid.
  - Each in_valid cycle writes one byte and increments count.
  - On the write with count==LOAD_LEN-1 -> RUN, count=0.
  - in_valid=0 stalls with no write and count unchanged.
- RUN:
  - core_reset=0; in_ready=0; mem_wr_en=0; mem_addr=0.
  - core_done is ignored in the first RUN cycle, because the core is still leaving reset.
  - From the second RUN cycle on, core_done=1 -> DUMP, count=0. core_reset returns to 1 in that same transition, so the core is held from the next cycle.
  - No timeout: RUN lasts until core_done.
- DUMP:
  - out_valid=1; mem_addr=(DUMP_BASE+count) mod 256; out_data=mem_rdata.
  - While out_ready=0, mem_addr, out_data and out_valid hold stable.
  - Each cycle with out_valid && out_ready increments count.
  - Handshake at count==DUMP_LEN-1 -> IDLE, or -> CSUM when CHECKSUM_EN is defined.
- Address arithmetic is 8-bit modulo; e.g. LOAD_BASE=250 with LOAD_LEN=10 writes 250..255 then 0..3.
- count is 9 bits so that length 256 works.
- Exactly LOAD_LEN writes and DUMP_LEN reads per sequence; no extra memory accesses.
- Reset mid-operation returns to IDLE immediately with core_reset=1. Memory contents already written are not cleared.
- The last LOAD write and the RUN entry are the same edge; the core never runs while a write is pending.

Optional Feature:
- Macro: DMEM_HOST_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR accumulator is cleared on the IDLE->LOAD transition.
  - It XORs every accepted load byte and every handshaken dump byte.
  - After the last dump handshake, state CSUM presents out_valid=1 with out_data=accumulator.
  - The CSUM handshake -> IDLE.
  - Accumulator reset value is 0.
- When not defined: no accumulator, no CSUM state, and DUMP goes directly to IDLE.

Test Plan:
1. Reset asserted mid-LOAD after 5 bytes -> next cycle state IDLE, core_reset=1, busy=0, in_ready=0. Bytes 0..4 remain in memory, and a new start reloads from LOAD_BASE.
2. Defaults; start, then 64 bytes 0x00..0x3F with in_valid gapped every 3rd cycle -> exactly 64 writes to addresses 0..63 with matching data, in_ready=0 after the last, core_reset falls the next cycle.
3. RUN with core_done held 1 from reset -> not taken in the first RUN cycle; DUMP entered on the second cycle, core_reset high again the following cycle.
4. DUMP with mem[64..95]=0xA0+i and out_ready toggling 1,0,0,1… -> 32 output bytes 0xA0..0xBF in order; out_data and mem_addr stable during stalls; busy=0 after the last.
5. LOAD_BASE=250, LOAD_LEN=10 -> writes to 250..255 then 0..3. DUMP_LEN=256 -> 256 outputs covering every address once.
6. With DMEM_HOST_CHECKSUM_EN defined, load bytes all 0x01 (LOAD_LEN=64, XOR 0x00) and dump bytes 0x5A then zeros -> a 33rd output byte 0x5A, then IDLE.

Source files
------------

// File: rtl/dmem_host_port.sv
// dmem_host_port: host-side initiator for the core's data memory.
// Sequence: IDLE -> LOAD (stream bytes in while the core is held in reset)
// -> RUN (core released, wait for core_done) -> DUMP (core held again,
// stream a window of data memory out) -> IDLE.
// Optional feature macro: DMEM_HOST_CHECKSUM_EN adds an XOR accumulator over
// all loaded and dumped bytes, presented as one extra output byte (CSUM state).
module dmem_host_port #(
   parameter int unsigned LOAD_BASE = 0,
   parameter int unsigned LOAD_LEN  = 64,
   parameter int unsigned DUMP_BASE = 64,
   parameter int unsigned DUMP_LEN  = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] mem_addr,
   output logic       mem_wr_en,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic       core_reset,
   input  logic       core_done,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy
);

   // Address bases reduced to 8 bits: all address arithmetic wraps mod 256.
   localparam logic [7:0] LOAD_BASE_B = LOAD_BASE[7:0];
   localparam logic [7:0] DUMP_BASE_B = DUMP_BASE[7:0];
   // Count is 9 bits so a length of 256 has a representable last index.
   localparam logic [8:0] LOAD_LAST = 9'(LOAD_LEN - 1);
   localparam logic [8:0] DUMP_LAST = 9'(DUMP_LEN - 1);

`ifdef DMEM_HOST_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RUN  = 3'd2,
      S_DUMP = 3'd3,
      S_CSUM = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DUMP = 2'd3
   } state_t;
`endif

   state_t     state_q;
   logic [8:0] count_q;
   // High only during the first RUN cycle, while the core is still leaving reset.
   logic       first_q;

   logic       load_fire;
   logic       dump_fire;

   assign load_fire = (state_q == S_LOAD) && in_valid;
   assign dump_fire = (state_q == S_DUMP) && out_ready;

`ifdef DMEM_HOST_CHECKSUM_EN
   logic [7:0] acc_q;

   // XOR accumulator over every accepted load byte and every handshaken dump byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= 8'h00;
      end else if ((state_q == S_IDLE) && start) begin
         acc_q <= 8'h00;
      end else if (load_fire) begin
         acc_q <= acc_q ^ in_data;
      end else if (dump_fire) begin
         acc_q <= acc_q ^ mem_rdata;
      end
   end
`endif

   // Sequencer: state, byte count and first-RUN-cycle flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= 9'd0;
         first_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_LOAD;
                  count_q <= 9'd0;
               end
            end
            S_LOAD: begin
               if (load_fire) begin
                  if (count_q == LOAD_LAST) begin
                     // Last write and RUN entry share this edge.
                     state_q <= S_RUN;
                     count_q <= 9'd0;
                     first_q <= 1'b1;
                  end else begin
                     count_q <= count_q + 9'd1;
                  end
               end
            end
            S_RUN: begin
               if (first_q) begin
                  first_q <= 1'b0;
               end else if (core_done) begin
                  state_q <= S_DUMP;
                  count_q <= 9'd0;
               end
            end
            S_DUMP: begin
               if (dump_fire) begin
                  if (count_q == DUMP_LAST) begin
`ifdef DMEM_HOST_CHECKSUM_EN
                     state_q <= S_CSUM;
`else
                     state_q <= S_IDLE;
`endif
                     count_q <= 9'd0;
                  end else begin
                     count_q <= count_q + 9'd1;
                  end
               end
            end
`ifdef DMEM_HOST_CHECKSUM_EN
            S_CSUM: begin
               if (out_ready) begin
                  state_q <= S_IDLE;
               end
            end
`endif
            default: begin
               state_q <= S_IDLE;
               count_q <= 9'd0;
               first_q <= 1'b0;
            end
         endcase
      end
   end

   // Output decode from registered state and count; the core is only out of reset in RUN.
   always_comb begin
      in_ready   = 1'b0;
      mem_addr   = 8'h00;
      mem_wr_en  = 1'b0;
      mem_wdata  = 8'h00;
      core_reset = 1'b1;
      out_data   = 8'h00;
      out_valid  = 1'b0;
      busy       = (state_q != S_IDLE);
      case (state_q)
         S_LOAD: begin
            in_ready  = 1'b1;
            mem_addr  = LOAD_BASE_B + count_q[7:0];
            mem_wdata = in_data;
            mem_wr_en = in_valid;
         end
         S_RUN: begin
            core_reset = 1'b0;
         end
         S_DUMP: begin
            out_valid = 1'b1;
            mem_addr  = DUMP_BASE_B + count_q[7:0];
            out_data  = mem_rdata;
         end
`ifdef DMEM_HOST_CHECKSUM_EN
         S_CSUM: begin
            out_valid = 1'b1;
            out_data  = acc_q;
         end
`endif
         default: begin
            mem_addr = 8'h00;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_host_port.sv
// Bench for dmem_host_port: two instances (default parameters, and a wrapped
// load window with a full 256-byte dump), each with a behavioural data memory.
// Expected writes and dump bytes are queued as stimulus is set up and popped as
// the DUT produces them. Honors DMEM_HOST_CHECKSUM_EN for the extra byte.
module tb_dmem_host_port;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // ---------------- instance A (defaults) ----------------
   logic       start_a, in_valid_a, in_ready_a, mem_wr_en_a, core_reset_a;
   logic       core_done_a, out_valid_a, out_ready_a, busy_a;
   logic [7:0] in_data_a, mem_addr_a, mem_wdata_a, mem_rdata_a, out_data_a;

   // ---------------- instance B (wrap / long dump) ----------------
   logic       start_b, in_valid_b, in_ready_b, mem_wr_en_b, core_reset_b;
   logic       core_done_b, out_valid_b, out_ready_b, busy_b;
   logic [7:0] in_data_b, mem_addr_b, mem_wdata_b, mem_rdata_b, out_data_b;

   dmem_host_port dut_a (
      .clk(clk), .reset(rst), .start(start_a),
      .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .mem_addr(mem_addr_a), .mem_wr_en(mem_wr_en_a), .mem_wdata(mem_wdata_a),
      .mem_rdata(mem_rdata_a), .core_reset(core_reset_a), .core_done(core_done_a),
      .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .busy(busy_a)
   );

   dmem_host_port #(.LOAD_BASE(250), .LOAD_LEN(10), .DUMP_BASE(7), .DUMP_LEN(256)) dut_b (
      .clk(clk), .reset(rst), .start(start_b),
      .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .mem_addr(mem_addr_b), .mem_wr_en(mem_wr_en_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b), .core_reset(core_reset_b), .core_done(core_done_b),
      .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .busy(busy_b)
   );

   // Behavioural data memories with a bench-side preload port.
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic       pre_we_a, pre_we_b;
   logic [7:0] pre_addr_a, pre_data_a, pre_addr_b, pre_data_b;
   int         wr_cnt_a = 0;
   int         wr_cnt_b = 0;

   always @(posedge clk) begin
      if (pre_we_a) mem_a[pre_addr_a] <= pre_data_a;
      else if (mem_wr_en_a) begin
         mem_a[mem_addr_a] <= mem_wdata_a;
         wr_cnt_a <= wr_cnt_a + 1;
      end
   end

   always @(posedge clk) begin
      if (pre_we_b) mem_b[pre_addr_b] <= pre_data_b;
      else if (mem_wr_en_b) begin
         mem_b[mem_addr_b] <= mem_wdata_b;
         wr_cnt_b <= wr_cnt_b + 1;
      end
   end

   assign mem_rdata_a = mem_a[mem_addr_a];
   assign mem_rdata_b = mem_b[mem_addr_b];

   int checks = 0;
   int errors = 0;

   logic [15:0] ld_q[$];      // expected {addr, data} writes
   logic [16:0] exp_q[$];     // expected {is_csum, addr, data} outputs
   logic [7:0]  csum_a, csum_b;
   logic [7:0]  exp_b [256];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_a = 0; in_valid_a = 0; in_data_a = 0; core_done_a = 0; out_ready_a = 0;
      start_b = 0; in_valid_b = 0; in_data_b = 0; core_done_b = 0; out_ready_b = 0;
      pre_we_a = 0; pre_addr_a = 0; pre_data_a = 0;
      pre_we_b = 0; pre_addr_b = 0; pre_data_b = 0;
      tick(); tick();
      @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      checks++; if (core_reset_a !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b want 1", core_reset_a); end
      checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready_a); end
      checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
      checks++; if (mem_wr_en_a !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en_a); end
      checks++; if (mem_addr_a !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", mem_addr_a); end
      checks++; if (out_data_a !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data_a); end
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
      $display("reset: outputs sampled");
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      int w0;
      w0 = wr_cnt_a;
      start_a = 1; tick(); start_a = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid_a = 1; in_data_a = 8'(8'h10 + i);
         tick();
      end
      in_valid_a = 0;
      #2 rst = 1'b1;
      #1;
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy_a); end
      checks++; if (core_reset_a !== 1'b1) begin errors++; $display("FAIL midreset_core_reset: got %b want 1", core_reset_a); end
      checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL midreset_in_ready: got %b want 0", in_ready_a); end
      checks++; if (wr_cnt_a - w0 !== 5) begin errors++; $display("FAIL midreset_writes: got %0d want 5", wr_cnt_a - w0); end
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (mem_a[i] !== 8'(8'h10 + i)) begin
            errors++; $display("FAIL midreset_retain[%0d]: got %h want %h", i, mem_a[i], 8'(8'h10 + i));
         end
      end
      $display("reset_mid_load: 5 bytes then reset");
   endtask

   task automatic preload_a();
      for (int i = 0; i < 32; i++) begin
         pre_we_a = 1; pre_addr_a = 8'(64 + i); pre_data_a = 8'(8'hA0 + i);
         exp_q.push_back({1'b0, 8'(64 + i), 8'(8'hA0 + i)});
         tick();
      end
      pre_we_a = 0;
   endtask

   task automatic test_load();
      int w0, idx, cyc, bad;
      logic [15:0] e;
      core_done_a = 1;            // held high; must be ignored until RUN allows it
      csum_a = 8'h00;
      w0 = wr_cnt_a; idx = 0; cyc = 0;
      start_a = 1; tick(); start_a = 0;
      while (idx < 64 && cyc < 500) begin
         in_valid_a = (cyc % 3 != 2);
         in_data_a  = 8'(idx);
         if (in_valid_a) ld_q.push_back({8'(idx), 8'(idx)});
         @(negedge clk);
         checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL load_in_ready: got %b want 1", in_ready_a); end
         checks++; if (mem_wr_en_a !== in_valid_a) begin errors++; $display("FAIL load_wr_en: got %b want %b", mem_wr_en_a, in_valid_a); end
         if (mem_wr_en_a === 1'b1 && ld_q.size() > 0) begin
            e = ld_q.pop_front();
            checks++;
            if ({mem_addr_a, mem_wdata_a} !== e) begin
               errors++; $display("FAIL load_write: got addr %h data %h want addr %h data %h", mem_addr_a, mem_wdata_a, e[15:8], e[7:0]);
            end
            $display("load: addr %h data %h", mem_addr_a, mem_wdata_a);
         end
         if (in_valid_a) begin csum_a ^= 8'(idx); idx++; end
         cyc++;
         tick();
      end
      in_valid_a = 0;
      checks++; if (idx != 64) begin errors++; $display("FAIL load_timeout: got %0d bytes want 64", idx); end
      checks++; if (wr_cnt_a - w0 !== 64) begin errors++; $display("FAIL load_write_count: got %0d want 64", wr_cnt_a - w0); end
      checks++; if (ld_q.size() != 0) begin errors++; $display("FAIL load_missing: got %0d pending want 0", ld_q.size()); end
      bad = 0;
      for (int i = 0; i < 64; i++) if (mem_a[i] !== 8'(i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL load_mem_contents: got %0d bad bytes want 0", bad); end
   endtask

   task automatic test_run();
      @(negedge clk);
      checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL run_in_ready: got %b want 0", in_ready_a); end
      checks++; if (core_reset_a !== 1'b0) begin errors++; $display("FAIL run_core_reset1: got %b want 0", core_reset_a); end
      checks++; if (mem_wr_en_a !== 1'b0) begin errors++; $display("FAIL run_wr_en: got %b want 0", mem_wr_en_a); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL run_busy: got %b want 1", busy_a); end
      tick();
      @(negedge clk);
      checks++; if (core_reset_a !== 1'b0) begin errors++; $display("FAIL run_core_reset2: got %b want 0", core_reset_a); end
      checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL run_done_early: got out_valid %b want 0", out_valid_a); end
      tick();
      out_ready_a = 0;
      @(negedge clk);
      checks++; if (core_reset_a !== 1'b1) begin errors++; $display("FAIL run_core_reset3: got %b want 1", core_reset_a); end
      checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL run_dump_entry: got out_valid %b want 1", out_valid_a); end
      $display("run: core released two cycles, dump entered");
   endtask

   task automatic test_dump();
      int hs, cyc, k, want_hs;
      logic [16:0] e;
      logic [7:0]  acc;
      acc = csum_a;
      for (int i = 0; i < 32; i++) acc ^= 8'(8'hA0 + i);
      want_hs = 32;
`ifdef DMEM_HOST_CHECKSUM_EN
      exp_q.push_back({1'b1, 8'h00, acc});
      want_hs = 33;
`endif
      hs = 0; cyc = 0; k = 0;
      while (exp_q.size() > 0 && cyc < 400) begin
         @(negedge clk);
         e = exp_q[0];
         checks++;
         if (out_valid_a !== 1'b1) begin
            errors++; $display("FAIL dump_valid: got %b want 1", out_valid_a);
         end else begin
            if (!e[16]) begin
               checks++;
               if (mem_addr_a !== e[15:8]) begin errors++; $display("FAIL dump_addr: got %h want %h", mem_addr_a, e[15:8]); end
            end
            checks++;
            if (out_data_a !== e[7:0]) begin errors++; $display("FAIL dump_data: got %h want %h", out_data_a, e[7:0]); end
            if (out_ready_a) begin
               void'(exp_q.pop_front());
               hs++;
               $display("dump: byte %0d data %h", hs, out_data_a);
            end
         end
         cyc++;
         tick();
         k++;
         out_ready_a = (k % 4 == 0) || (k % 4 == 3);
      end
      out_ready_a = 0;
      checks++; if (hs != want_hs) begin errors++; $display("FAIL dump_count: got %0d want %0d", hs, want_hs); end
      @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL dump_busy_after: got %b want 0", busy_a); end
      checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL dump_valid_after: got %b want 0", out_valid_a); end
      tick();
   endtask

   task automatic test_wrap();
      int w0, hs, cyc, seen, want_hs;
      logic [15:0] e;
      logic [16:0] d;
      logic [7:0]  a;
      for (int i = 0; i < 256; i++) begin
         pre_we_b = 1; pre_addr_b = 8'(i); pre_data_b = 8'(i) ^ 8'h55;
         exp_b[i] = 8'(i) ^ 8'h55;
         tick();
      end
      pre_we_b = 0;
      w0 = wr_cnt_b; csum_b = 8'h00;
      start_b = 1; tick(); start_b = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid_b = 1; in_data_b = 8'(8'hC0 + i);
         a = 8'(250 + i);
         ld_q.push_back({a, 8'(8'hC0 + i)});
         exp_b[a] = 8'(8'hC0 + i);
         csum_b ^= 8'(8'hC0 + i);
         @(negedge clk);
         e = ld_q.pop_front();
         checks++;
         if (mem_wr_en_b !== 1'b1 || {mem_addr_b, mem_wdata_b} !== e) begin
            errors++; $display("FAIL wrap_write: got en %b addr %h data %h want addr %h data %h", mem_wr_en_b, mem_addr_b, mem_wdata_b, e[15:8], e[7:0]);
         end
         $display("wrap load: addr %h data %h", mem_addr_b, mem_wdata_b);
         tick();
      end
      in_valid_b = 0;
      checks++; if (wr_cnt_b - w0 !== 10) begin errors++; $display("FAIL wrap_write_count: got %0d want 10", wr_cnt_b - w0); end
      for (int i = 0; i < 256; i++) begin
         a = 8'(7 + i);
         exp_q.push_back({1'b0, a, exp_b[a]});
         csum_b ^= exp_b[a];
      end
      want_hs = 256;
`ifdef DMEM_HOST_CHECKSUM_EN
      exp_q.push_back({1'b1, 8'h00, csum_b});
      want_hs = 257;
`endif
      tick(); tick();
      core_done_b = 1;
      hs = 0; cyc = 0; seen = 0;
      while (exp_q.size() > 0 && cyc < 2000) begin
         out_ready_b = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (out_valid_b === 1'b1) begin
            seen = 1;
            d = exp_q[0];
            if (!d[16]) begin
               checks++;
               if (mem_addr_b !== d[15:8]) begin errors++; $display("FAIL wrap_dump_addr: got %h want %h", mem_addr_b, d[15:8]); end
            end
            checks++;
            if (out_data_b !== d[7:0]) begin errors++; $display("FAIL wrap_dump_data: got %h want %h", out_data_b, d[7:0]); end
            if (out_ready_b) begin void'(exp_q.pop_front()); hs++; end
         end else if (seen) begin
            checks++; errors++;
            $display("FAIL wrap_dump_valid: got 0 want 1 at output %0d", hs);
            break;
         end
         cyc++;
         tick();
      end
      out_ready_b = 0; core_done_b = 0;
      $display("wrap dump: %0d outputs", hs);
      checks++; if (hs != want_hs) begin errors++; $display("FAIL wrap_dump_count: got %0d want %0d", hs, want_hs); end
      @(negedge clk);
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL wrap_busy_after: got %b want 0", busy_b); end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_reset_mid_load();
      preload_a();
      test_load();
      test_run();
      test_dump();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
